aes_bus_interface: RTL and testbench

AES_BUS_INTERFACE -- requirements
Module: aes_bus_interface

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_word_shift.sv | 28 ++
 rtl/aes_bus_interface.sv | 168 ++++++++++++++++
 tb/tb_aes_bus_interface.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES host bus interface: FSM states, register
// addresses and STATUS bit positions.
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READY = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } aes_state_e;

   localparam logic [1:0] ADDR_MSG    = 2'd0;
   localparam logic [1:0] ADDR_KEY    = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_CRYPTE = 2'd3;

   localparam int STAT_READY = 0;
   localparam int STAT_BUSY  = 1;
   localparam int STAT_DONE  = 2;
   localparam int STAT_OVF   = 3;
   localparam int STAT_ERR   = 4;
   localparam int STAT_UNF   = 5;

   // CTRL write bit positions
   localparam int CTRL_START = 0;
   localparam int CTRL_CLR   = 1;
   localparam int CTRL_RST   = 2;
   localparam int CTRL_IRQC  = 3;

endpackage

// File: rtl/aes_word_shift.sv
// Word-wide shift register: shifts a word in at the bottom (oldest word ends up
// on top) and optionally parallel-loads a full block.
module aes_word_shift #(
   parameter int WIDTH  = 128,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_data,
   input  logic              shift,
   input  logic [WORD_W-1:0] shift_in,
   output logic [WIDTH-1:0]  data
);

   // NOTE: the block storage is reset too, so no stale key or plaintext
   // survives a reset; non-blocking assignments keep register updates ordered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data <= '0;
      end else if (load) begin
         data <= load_data;
      end else if (shift) begin
         data <= {data[WIDTH-WORD_W-1:0], shift_in};
      end
   end

endmodule

// File: rtl/aes_bus_interface.sv
// Host bus front-end for an AES core: assembles message/key words, sequences
// start, and drains the ciphertext word by word. Optional irq: AES_IF_IRQ_EN.
module aes_bus_interface
   import aes_pkg::*;
#(
   parameter int BUS_W = 32,
   parameter int KEY_W = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs,
   input  logic             rw,
   input  logic [1:0]       addr,
   input  logic [BUS_W-1:0] wdata,
   output logic [BUS_W-1:0] rdata,
   output logic [127:0]     message,
   output logic [KEY_W-1:0] key,
   output logic             start,
   input  logic [127:0]     crypte,
   input  logic             crypte_valid
`ifdef AES_IF_IRQ_EN
   ,output logic            irq
`endif
);

   localparam int MSG_WORDS = 128 / BUS_W;
   localparam int KEY_WORDS = KEY_W / BUS_W;
   localparam int MCW       = $clog2(MSG_WORDS + 1);
   localparam int KCW       = $clog2(KEY_WORDS + 1);

   aes_state_e     state, state_nxt;
   logic [MCW-1:0] msg_cnt, out_cnt;
   logic [KCW-1:0] key_cnt;
   logic           ovf, err, unf;
   logic [127:0]   out_data;

   logic wr_acc, rd_acc, wr_msg, wr_key, wr_ctrl, rd_status, rd_crypte;
   logic msg_full, key_full, msg_take, key_take;
   logic ovf_set, err_set, unf_set, sticky_clr;
   logic ctrl_clr, start_req, go, capture, drain_rd, last_rd;
   logic [BUS_W-1:0] status_word;

   assign wr_acc    = cs & ~rw;
   assign rd_acc    = cs & rw;
   assign wr_msg    = wr_acc && (addr == ADDR_MSG);
   assign wr_key    = wr_acc && (addr == ADDR_KEY);
   assign wr_ctrl   = wr_acc && (addr == ADDR_CTRL);
   assign rd_status = rd_acc && (addr == ADDR_CTRL);
   assign rd_crypte = rd_acc && (addr == ADDR_CRYPTE);

   assign msg_full = (msg_cnt == MCW'(MSG_WORDS));
   assign key_full = (key_cnt == KCW'(KEY_WORDS));
   assign msg_take = wr_msg && (state != ST_RUN) && !msg_full;
   assign key_take = wr_key && (state != ST_RUN) && !key_full;

   // A soft clear cannot interrupt an encryption in flight, and it beats start.
   assign ctrl_clr  = wr_ctrl && wdata[CTRL_RST] && (state != ST_RUN);
   assign start_req = wr_ctrl && wdata[CTRL_START] && !ctrl_clr;
   assign go        = start_req && (state == ST_READY);
   assign capture   = crypte_valid && (state == ST_RUN);
   assign drain_rd  = rd_crypte && (state == ST_DRAIN);
   assign last_rd   = drain_rd && (out_cnt == MCW'(1));

   assign ovf_set    = (state != ST_RUN) &&
                       ((wr_msg && msg_full) || (wr_key && key_full));
   assign err_set    = ((wr_msg || wr_key) && (state == ST_RUN)) ||
                       (start_req && (state != ST_READY));
   assign unf_set    = rd_crypte && (state != ST_DRAIN);
   assign sticky_clr = wr_ctrl && wdata[CTRL_CLR];

   aes_word_shift #(.WIDTH(128), .WORD_W(BUS_W)) u_msg (
      .clk(clk), .reset(reset), .load(1'b0), .load_data('0),
      .shift(msg_take), .shift_in(wdata), .data(message)
   );

   aes_word_shift #(.WIDTH(KEY_W), .WORD_W(BUS_W)) u_key (
      .clk(clk), .reset(reset), .load(1'b0), .load_data('0),
      .shift(key_take), .shift_in(wdata), .data(key)
   );

   aes_word_shift #(.WIDTH(128), .WORD_W(BUS_W)) u_out (
      .clk(clk), .reset(reset), .load(capture), .load_data(crypte),
      .shift(drain_rd), .shift_in('0), .data(out_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!ctrl_clr && msg_full && key_full) state_nxt = ST_READY;
         ST_READY: if (ctrl_clr)     state_nxt = ST_IDLE;
                   else if (go)      state_nxt = ST_RUN;
         ST_RUN:   if (capture)      state_nxt = ST_DRAIN;
         ST_DRAIN: if (ctrl_clr || last_rd) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         msg_cnt <= '0;
         key_cnt <= '0;
         out_cnt <= '0;
      end else begin
         // Draining the last word frees the message slot; the key is kept for reuse.
         if (ctrl_clr || last_rd) msg_cnt <= '0;
         else if (msg_take)       msg_cnt <= msg_cnt + MCW'(1);

         if (ctrl_clr)            key_cnt <= '0;
         else if (key_take)       key_cnt <= key_cnt + KCW'(1);

         if (capture)             out_cnt <= MCW'(MSG_WORDS);
         else if (ctrl_clr)       out_cnt <= '0;
         else if (drain_rd)       out_cnt <= out_cnt - MCW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf   <= 1'b0;
         err   <= 1'b0;
         unf   <= 1'b0;
         start <= 1'b0;
      end else begin
         ovf   <= (ovf & ~sticky_clr) | ovf_set;
         err   <= (err & ~sticky_clr) | err_set;
         unf   <= (unf & ~sticky_clr) | unf_set;
         start <= go;
      end
   end

   always_comb begin
      status_word = '0;
      status_word[STAT_READY] = (state == ST_READY);
      status_word[STAT_BUSY]  = (state == ST_RUN);
      status_word[STAT_DONE]  = (state == ST_DRAIN);
      status_word[STAT_OVF]   = ovf;
      status_word[STAT_ERR]   = err;
      status_word[STAT_UNF]   = unf;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (rd_acc) begin
         if (rd_status)     rdata <= status_word;
         else if (drain_rd) rdata <= out_data[127 -: BUS_W];
         else               rdata <= '0;
      end
   end

`ifdef AES_IF_IRQ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq <= 1'b0;
      end else begin
         irq <= (irq & ~(wr_ctrl & wdata[CTRL_IRQC])) | capture |
                ovf_set | err_set | unf_set;
      end
   end
`endif

endmodule

// File: tb/tb_aes_bus_interface.sv
// Directed bench for aes_bus_interface: a 32/128 instance and an 8/256 instance
// sharing clock, reset and the ciphertext inputs.
module tb_aes_bus_interface;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] crypte;
   logic         crypte_valid;

   logic         cs, rw;
   logic [1:0]   addr;
   logic [31:0]  wdata, rdata;
   logic [127:0] message;
   logic [127:0] key;
   logic         start;

   logic         cs8, rw8;
   logic [1:0]   addr8;
   logic [7:0]   wdata8, rdata8;
   logic [127:0] message8;
   logic [255:0] key8;
   logic         start8;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   aes_bus_interface #(.BUS_W(32), .KEY_W(128)) u_dut (
      .clk(clk), .reset(reset), .cs(cs), .rw(rw), .addr(addr), .wdata(wdata),
      .rdata(rdata), .message(message), .key(key), .start(start),
      .crypte(crypte), .crypte_valid(crypte_valid)
   );

   aes_bus_interface #(.BUS_W(8), .KEY_W(256)) u_dut8 (
      .clk(clk), .reset(reset), .cs(cs8), .rw(rw8), .addr(addr8), .wdata(wdata8),
      .rdata(rdata8), .message(message8), .key(key8), .start(start8),
      .crypte(crypte), .crypte_valid(crypte_valid)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One bus access: driven on a falling edge, taken on the next rising edge,
   // registered read data sampled on the following falling edge.
   task automatic access(input bit d8, input bit is_rd, input logic [1:0] a,
                         input logic [31:0] d, output logic [31:0] rv);
      @(negedge clk);
      if (d8) begin
         cs8 = 1'b1; rw8 = is_rd; addr8 = a; wdata8 = d[7:0];
      end else begin
         cs = 1'b1; rw = is_rd; addr = a; wdata = d;
      end
      @(negedge clk);
      cs  = 1'b0;
      cs8 = 1'b0;
      rv  = d8 ? {24'h0, rdata8} : rdata;
   endtask

   task automatic wr(input bit d8, input logic [1:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      access(d8, 1'b0, a, d, dummy);
   endtask

   task automatic rd_check(input bit d8, input logic [1:0] a, input logic [31:0] exp,
                           input string tag);
      logic [31:0] v;
      access(d8, 1'b1, a, 32'h0, v);
      check(tag, 256'(v), 256'(exp));
   endtask

   task automatic pulse_crypte(input logic [127:0] v);
      @(negedge clk);
      crypte = v;
      crypte_valid = 1'b1;
      @(negedge clk);
      crypte_valid = 1'b0;
   endtask

   task automatic load_std32();
      wr(0, 2'd0, 32'h00112233);
      wr(0, 2'd0, 32'h44556677);
      wr(0, 2'd0, 32'h8899AABB);
      wr(0, 2'd0, 32'hCCDDEEFF);
      wr(0, 2'd1, 32'h01020304);
      wr(0, 2'd1, 32'h05060708);
      wr(0, 2'd1, 32'h090A0B0C);
      wr(0, 2'd1, 32'h0D0E0F10);
   endtask

   initial begin
      logic [127:0] exp_ct;
      logic [127:0] msg_snap;

      reset = 1'b0;
      cs = 1'b0; rw = 1'b0; addr = 2'd0; wdata = '0;
      cs8 = 1'b0; rw8 = 1'b0; addr8 = 2'd0; wdata8 = '0;
      crypte = '0; crypte_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdata", 256'(rdata), 256'h0);
      check("rst_message", 256'(message), 256'h0);
      check("rst_start", 256'(start), 256'h0);
      reset = 1'b1;
      rd_check(0, 2'd2, 32'h00, "rst_status");

      // Assemble block and key, expect READY
      load_std32();
      check("msg_assembled", 256'(message), 256'h00112233_44556677_8899AABB_CCDDEEFF);
      check("key_assembled", 256'(key), 256'h01020304_05060708_090A0B0C_0D0E0F10);
      rd_check(0, 2'd2, 32'h01, "status_ready");

      // Start: exactly one cycle
      check("start_idle_low", 256'(start), 256'h0);
      wr(0, 2'd2, 32'h1);
      check("start_pulse_hi", 256'(start), 256'h1);
      @(negedge clk);
      check("start_pulse_lo", 256'(start), 256'h0);
      rd_check(0, 2'd2, 32'h02, "status_busy");

      // MSG write while RUN is discarded with ERR
      wr(0, 2'd0, 32'hFFFFFFFF);
      check("run_msg_stable", 256'(message), 256'h00112233_44556677_8899AABB_CCDDEEFF);
      rd_check(0, 2'd2, 32'h12, "status_run_err");
      wr(0, 2'd2, 32'h2);
      rd_check(0, 2'd2, 32'h02, "status_err_cleared");

      // Ciphertext capture and drain
      pulse_crypte({4{32'hA5A5A5A5}});
      rd_check(0, 2'd2, 32'h04, "status_done");
      for (int i = 0; i < 4; i++) rd_check(0, 2'd3, 32'hA5A5A5A5, "crypte_word");
      rd_check(0, 2'd2, 32'h00, "status_after_drain");

      // Key retained: a fresh message alone reaches READY; 5th word overflows
      wr(0, 2'd0, 32'hDEADBEEF);
      wr(0, 2'd0, 32'hCAFEF00D);
      wr(0, 2'd0, 32'h12345678);
      wr(0, 2'd0, 32'h9ABCDEF0);
      check("msg_second", 256'(message), 256'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
      rd_check(0, 2'd2, 32'h01, "status_key_reuse");
      wr(0, 2'd0, 32'h55555555);
      check("msg_ovf_discard", 256'(message), 256'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
      rd_check(0, 2'd2, 32'h09, "status_ovf");
      wr(0, 2'd2, 32'h2);
      rd_check(0, 2'd2, 32'h01, "status_ovf_cleared");

      // Start and clear together: clear wins
      wr(0, 2'd2, 32'h5);
      check("clr_beats_start", 256'(start), 256'h0);
      rd_check(0, 2'd2, 32'h00, "status_after_clr");

      // Start in IDLE and CRYPTE read in IDLE
      wr(0, 2'd2, 32'h1);
      check("idle_no_start", 256'(start), 256'h0);
      rd_check(0, 2'd2, 32'h10, "status_err");
      rd_check(0, 2'd3, 32'h0, "crypte_idle_zero");
      rd_check(0, 2'd2, 32'h30, "status_err_unf");
      wr(0, 2'd2, 32'h2);
      pulse_crypte({4{32'h5A5A5A5A}});
      rd_check(0, 2'd2, 32'h00, "crypte_valid_idle_ignored");

      // Reset mid-RUN abandons the operation
      load_std32();
      wr(0, 2'd2, 32'h1);
      rd_check(0, 2'd2, 32'h02, "status_run_again");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("async_rst_msg", 256'(message), 256'h0);
      check("async_rst_key", 256'(key), 256'h0);
      check("async_rst_rdata", 256'(rdata), 256'h0);
      @(negedge clk);
      reset = 1'b1;
      pulse_crypte({4{32'hA5A5A5A5}});
      rd_check(0, 2'd2, 32'h00, "status_after_rst_run");

      // 8-bit bus, 256-bit key
      for (int i = 0; i < 16; i++) wr(1, 2'd0, 32'(i));
      for (int i = 0; i < 32; i++) wr(1, 2'd1, 32'(8'h20 + i));
      check("msg8", 256'(message8), 256'h000102030405060708090A0B0C0D0E0F);
      check("key8", key8,
            256'h202122232425262728292A2B2C2D2E2F303132333435363738393A3B3C3D3E3F);
      rd_check(1, 2'd2, 32'h01, "status8_ready");
      wr(1, 2'd2, 32'h1);
      check("start8_pulse", 256'(start8), 256'h1);
      msg_snap = 128'h0123456789ABCDEFFEDCBA9876543210;
      pulse_crypte(msg_snap);
      rd_check(1, 2'd2, 32'h04, "status8_done");
      exp_ct = msg_snap;
      for (int i = 0; i < 16; i++) begin
         rd_check(1, 2'd3, {24'h0, exp_ct[127:120]}, "crypte8_byte");
         exp_ct = exp_ct << 8;
      end
      rd_check(1, 2'd2, 32'h00, "status8_after_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
